serial_parity_checker: RTL and testbench



---
 rtl/serial_parity_checker_if.sv | 23 ++
 rtl/serial_parity_checker.sv | 113 +++++++++++
 tb/tb_serial_parity_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_checker_if.sv
// Serial parity checker bus: frame control, serial bit input,
// and the received word / parity-error results.
interface serial_parity_checker_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 bit_valid;
  logic                 bit_in;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;

  modport master (
    output start, bit_valid, bit_in,
    input  busy, done, data_out, parity_err
  );

  modport slave (
    input  start, bit_valid, bit_in,
    output busy, done, data_out, parity_err
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserializes DATA_BITS bits LSB first plus
// one parity bit, keeping a running XOR to flag parity mismatches.
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_parity_checker_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic ODD_B = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 busy_o, done_o;

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next state: shift data bits in at the MSB, then check parity
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          for (int i = 0; i < DATA_BITS - 1; i++) begin
            shr_d[i] = shr_q[i+1];
          end
          shr_d[DATA_BITS-1] = bus.bit_in;
          acc_d = acc_q ^ bus.bit_in;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bus.bit_valid) begin
          err_d   = acc_q ^ bus.bit_in ^ ODD_B;
          data_d  = shr_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decode from the registered state only
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (1'b1)
      (state_q == DATA),
      (state_q == PARITY): busy_o = 1'b1;
      (state_q == DONE):   done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.data_out   = data_q;
  assign bus.parity_err = err_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one
// bit stream; a scoreboard holds expected results per frame.
module tb_serial_parity_checker;
  logic clk;
  logic rst_n;
  logic start, bv, bi;

  serial_parity_checker_if #(.DATA_BITS(8)) b0 ();
  serial_parity_checker_if #(.DATA_BITS(8)) b1 ();

  assign b0.start     = start;
  assign b0.bit_valid = bv;
  assign b0.bit_in    = bi;
  assign b1.start     = start;
  assign b1.bit_valid = bv;
  assign b1.bit_in    = bi;

  serial_parity_checker #(.DATA_BITS(8), .ODD(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         g3;
    int         gp;
    bit         mid;
    bit         b2b;
    logic [7:0] ed;
    logic       e0;
    logic       e1;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       e0;
    logic       e1;
    int         st;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[10];
  vec_t post;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    e.d   = v.ed;
    e.e0  = v.e0;
    e.e1  = v.e1;
    e.st  = cyc + 1;
    e.lat = 10 + v.g3 + v.gp;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", {31'd0, b0.busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      bv = 1'b1;
      bi = v.d[i];
      if (v.mid && i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bv = 1'b0;
      bi = 1'($urandom);
      if (i == 3) begin
        for (int g = 0; g < v.g3; g++) begin
          start = v.mid;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    for (int g = 0; g < v.gp; g++) @(negedge clk);
    bv = 1'b1;
    bi = v.p;
    @(negedge clk);
    bv = 1'b0;
  endtask

  // Output monitor: one sample per cycle, just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (b0.done) begin
        chk("done_width", {31'd0, prev_done}, 32'd0);
        chk("busy_in_done", {31'd0, b0.busy}, 32'd0);
        chk("done_pair", {31'd0, b1.done}, 32'd1);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty queue");
        end else begin
          e = sbq.pop_front();
          chk("data0", {24'd0, b0.data_out}, {24'd0, e.d});
          chk("data1", {24'd0, b1.data_out}, {24'd0, e.d});
          chk("err_even", {31'd0, b0.parity_err}, {31'd0, e.e0});
          chk("err_odd", {31'd0, b1.parity_err}, {31'd0, e.e1});
          chk("latency", cyc - e.st + 1, e.lat);
        end
      end
      prev_done = b0.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 0, 0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b0, 0, 0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 0, 0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 2, 1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[5] = '{8'h01, 1'b1, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 1'b0, 0, 0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{8'hFF, 1'b1, 0, 0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[9] = '{8'hA5, 1'b0, 0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    post   = '{8'hFF, 1'b0, 0, 0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    bv    = 1'b0;
    bi    = 1'b0;
    #12;
    chk("rst_busy", {31'd0, b0.busy}, 32'd0);
    chk("rst_done", {31'd0, b0.done}, 32'd0);
    chk("rst_data", {24'd0, b0.data_out}, 32'd0);
    chk("rst_err", {31'd0, b0.parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bv = 1'b1;
    bi = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    chk("idle_ignores_bits", {31'd0, b0.busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].b2b) @(negedge clk);
      send(tbl[i]);
    end

    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bv = 1'b1;
      bi = 1'b1;
      @(negedge clk);
    end
    bv = 1'b0;
    chk("pre_abort_busy", {31'd0, b0.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, b0.busy}, 32'd0);
    chk("abort_done", {31'd0, b0.done}, 32'd0);
    chk("abort_data", {24'd0, b0.data_out}, 32'd0);
    chk("abort_err", {31'd0, b1.parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(post);

    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
